i2c_reg_target: RTL
===================

Name: i2c_reg_target

Overview:
- I2C target (responder) that receives register writes of the form [addr+W][reg][data...], as produced by the team's 16-bit config writer, and serves register reads.
- Runs on a system clock that oversamples SCL/SDA. Exposes a simple register-bus strobe interface to a local register file.
- Used as a simulation/loopback model of the HDMI transmitter's control port and as an on-FPGA config target (e.g. DDC/EDID-style ports).

Parameters:
- I2C_ADDR, 7'h39, 7-bit target address matched on the bus.
- FILTER_LEN, 3, clk cycles a synchronized SCL/SDA level must be stable before it is accepted (1..15).

Ports:
- clk  in  1  system clock; must be ≥ 16× SCL frequency.
- reset  in  1  asynchronous, active-high reset.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- reg_addr  out  8  current register pointer.
- wr_data  out  8  byte received for a write.
- wr_strobe  out  1  one-cycle pulse: write wr_data to reg_addr.
- rd_data  in  8  register-file contents at reg_addr; combinational from the register file.
- rd_strobe  out  1  one-cycle pulse: rd_data has been latched and reg_addr is about to increment.
- busy  out  1  high from an accepted START to the next STOP.

Behaviour:
- Reset values: sda_oe=0, reg_addr=0, wr_data=0, wr_strobe=0, rd_strobe=0, busy=0, state=IDLE.
- Input conditioning: 2-FF synchronizer, then a glitch filter. The filtered level changes only after FILTER_LEN consecutive equal samples.
- Edge events (all on filtered signals):
  - SCL rise and SCL fall.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
- Event priority: START and STOP override all states.
  - STOP → IDLE, sda_oe=0, busy=0.
  - START, including a repeated START → ADDR, bit counter=0, busy=1.
- Shift timing:
  - Data bits are sampled MSB first on SCL rise.
  - sda_oe changes only on SCL fall.
- States:
  - IDLE: waits for START.
  - ADDR: after 8 bits, compare [7:1] to I2C_ADDR.
    - Match → ADDR_ACK.
    - Mismatch → IDLE (no ACK, sda_oe stays 0 until the next START).
  - ADDR_ACK: assert sda_oe on the SCL fall after bit 8; release it on the next SCL fall.
    - W → REG.
    - R → RDATA; rd_data is latched into the shifter on that same SCL fall and rd_strobe pulses.
  - REG: 8 bits → reg_addr loaded on the SCL fall after bit 8 → REG_ACK (ACK as above) → WDATA.
  - WDATA: 8 bits → on the SCL fall after bit 8: wr_data loaded, wr_strobe pulses for 1 clk, ACK asserted → WDATA_ACK.
    - reg_addr increments (8-bit wrap, 0xFF→0x00) on the clk after wr_strobe.
    - WDATA_ACK → WDATA.
  - RDATA: drives sda_oe = ~shift[7] on each SCL fall; sda_oe is valid for bit 7 immediately after ADDR_ACK releases. After 8 bits → RACK.
  - RACK: release SDA; sample the controller's ACK on SCL rise.
    - ACK (0): on the next SCL fall, reg_addr increments, then rd_data is latched, rd_strobe pulses, → RDATA.
    - NACK (1): → IDLE and wait for STOP.
- Bytes interrupted by START/STOP are discarded: no wr_strobe, reg_addr unchanged.
- Write with no data byte ([addr+W][reg] STOP) only sets reg_addr. This supports the set-pointer-then-read flow via repeated START.
- Reset mid-transaction: immediate return to reset values; SDA released asynchronously.

Optional Feature:
- Macro: I2C_REG_TARGET_READ_EN.
- Defined: R-direction addressing is ACKed, and the RDATA/RACK path and rd_strobe are present.
- Undefined:
  - An address match with R=1 is not ACKed → IDLE.
  - rd_strobe is tied 0; rd_data is unused.
  - RDATA/RACK logic is not built.

Test Plan:
- START, 0x72 (0x39+W), 0x41, 0x10, STOP → three ACKs; one wr_strobe with reg_addr=0x41, wr_data=0x10; reg_addr=0x42 after; busy 1→0 at STOP.
- START, 0x72, 0xFF, 0xAA, 0xBB, STOP → wr_strobe at 0xFF/0xAA then 0x00/0xBB (wrap); final reg_addr=0x01.
- START, 0x74 (0x3A+W), 0x41, 0x10, STOP → sda_oe never asserted; no wr_strobe; reg_addr unchanged.
- With READ_EN: START, 0x72, 0x15, repeated START, 0x73, read 2 bytes (ACK, then NACK), STOP, with rd_data = reg_addr^0xFF → bus bytes 0xEA, 0xE9; rd_strobe twice.
- Without READ_EN: START, 0x73 → no ACK; sda_oe stays 0 for the whole transfer.
- reset asserted after bit 3 of a data byte, then released, then a full write 0x72, 0x03, 0x00 → sda_oe=0 immediately on reset; no strobe from the aborted byte; the new write is strobed correctly.
- Glitch: 1-clk SDA low pulse while SCL high in IDLE with FILTER_LEN=3 → no START detected; busy stays 0.

Source files
------------

// File: rtl/i2c_reg_target_if.sv
// Bus bundle for i2c_reg_target: raw I2C pins plus the register-file strobe port.
// master = bus/register-file side, slave = the I2C target itself.
interface i2c_reg_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic [7:0] rd_data;
  logic       rd_strobe;
  logic       busy;

  modport master (
    output scl_in, sda_in, rd_data,
    input  sda_oe, reg_addr, wr_data, wr_strobe, rd_strobe, busy
  );

  modport slave (
    input  scl_in, sda_in, rd_data,
    output sda_oe, reg_addr, wr_data, wr_strobe, rd_strobe, busy
  );
endinterface

// File: rtl/i2c_reg_target.sv
// I2C register target: oversampled SCL/SDA, [addr+W][reg][data...] writes, pointer reads.
// Read direction is built only when I2C_REG_TARGET_READ_EN is defined.
module i2c_reg_target #(
  parameter logic [6:0]  I2C_ADDR   = 7'h39,
  parameter int unsigned FILTER_LEN = 3
) (
  input logic             clk,
  input logic             reset,
  i2c_reg_target_if.slave bus
);

  localparam logic [3:0] FLT_MAX     = 4'(FILTER_LEN - 1);
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_REG       = 4'd3;
  localparam logic [3:0] S_REG_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
`ifdef I2C_REG_TARGET_READ_EN
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RACK      = 4'd8;
`endif

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_rise_s, scl_fall_s, start_s, stop_s, byte_done_s, addr_ok_s;

  logic [3:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       busy_q, busy_d;
  logic       inc_q, inc_d;
`ifdef I2C_REG_TARGET_READ_EN
  logic       rnw_q, rnw_d;
  logic       rd_strobe_q, rd_strobe_d;
  logic       rd_pend_q, rd_pend_d;
`else
  logic       unused_rd_data_s;
  assign unused_rd_data_s = ^bus.rd_data;
`endif

  // Glitch filter: the accepted level follows the synchronized pin only after FILTER_LEN equal samples.
  always_comb begin
    scl_f_d   = scl_f_q;
    scl_cnt_d = 4'd0;
    sda_f_d   = sda_f_q;
    sda_cnt_d = 4'd0;
    if (scl_sync_q[1] == scl_f_q) begin
      scl_cnt_d = 4'd0;
    end else if (scl_cnt_q == FLT_MAX) begin
      scl_f_d   = scl_sync_q[1];
      scl_cnt_d = 4'd0;
    end else begin
      scl_cnt_d = scl_cnt_q + 4'd1;
    end
    if (sda_sync_q[1] == sda_f_q) begin
      sda_cnt_d = 4'd0;
    end else if (sda_cnt_q == FLT_MAX) begin
      sda_f_d   = sda_sync_q[1];
      sda_cnt_d = 4'd0;
    end else begin
      sda_cnt_d = sda_cnt_q + 4'd1;
    end
  end

  // Synchronizers, filter state and previous filtered levels; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_cnt_q  <= 4'd0;
      sda_cnt_q  <= 4'd0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[0], bus.sda_in};
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  assign scl_rise_s  = scl_f_q & ~scl_prev_q;
  assign scl_fall_s  = ~scl_f_q & scl_prev_q;
  assign start_s     = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
  assign stop_s      = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;
  assign byte_done_s = (bit_cnt_q == 4'd8);
`ifdef I2C_REG_TARGET_READ_EN
  assign addr_ok_s   = (shift_q[7:1] == I2C_ADDR);
`else
  assign addr_ok_s   = (shift_q[7:1] == I2C_ADDR) & ~shift_q[0];
`endif

  // Protocol FSM: bits shift in on SCL rise, every SDA drive change happens on SCL fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = 1'b0;
    busy_d      = busy_q;
    inc_d       = 1'b0;
`ifdef I2C_REG_TARGET_READ_EN
    rnw_d       = rnw_q;
    rd_strobe_d = 1'b0;
    rd_pend_d   = 1'b0;
`endif
    if (inc_q) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end else begin
      reg_addr_d = reg_addr_q;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_ADDR: begin
        if (scl_rise_s) begin
          shift_d   = {shift_q[6:0], sda_f_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall_s && byte_done_s) begin
          bit_cnt_d = 4'd0;
          if (addr_ok_s) begin
            state_d  = S_ADDR_ACK;
            sda_oe_d = 1'b1;
`ifdef I2C_REG_TARGET_READ_EN
            rnw_d    = shift_q[0];
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_ADDR_ACK: begin
        if (scl_fall_s) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
`ifdef I2C_REG_TARGET_READ_EN
          if (rnw_q) begin
            // First read byte comes from the current pointer; bit 7 is driven right away.
            state_d     = S_RDATA;
            shift_d     = bus.rd_data;
            rd_strobe_d = 1'b1;
            sda_oe_d    = ~bus.rd_data[7];
          end else begin
            state_d = S_REG;
          end
`else
          state_d = S_REG;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_REG: begin
        if (scl_rise_s) begin
          shift_d   = {shift_q[6:0], sda_f_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall_s && byte_done_s) begin
          reg_addr_d = shift_q;
          sda_oe_d   = 1'b1;
          state_d    = S_REG_ACK;
        end else begin
          state_d = state_q;
        end
      end
      S_WDATA: begin
        if (scl_rise_s) begin
          shift_d   = {shift_q[6:0], sda_f_q};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall_s && byte_done_s) begin
          wr_data_d   = shift_q;
          wr_strobe_d = 1'b1;
          inc_d       = 1'b1;
          sda_oe_d    = 1'b1;
          state_d     = S_WDATA_ACK;
        end else begin
          state_d = state_q;
        end
      end
      S_REG_ACK, S_WDATA_ACK: begin
        if (scl_fall_s) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = S_WDATA;
        end else begin
          state_d = state_q;
        end
      end
`ifdef I2C_REG_TARGET_READ_EN
      S_RDATA: begin
        if (scl_rise_s) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall_s) begin
          if (byte_done_s) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            shift_d   = 8'h00;
            state_d   = S_RACK;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end else begin
          state_d = state_q;
        end
      end
      S_RACK: begin
        // After an ACK the pointer moves first, so rd_data is latched one clk later.
        if (rd_pend_q) begin
          shift_d     = bus.rd_data;
          rd_strobe_d = 1'b1;
          sda_oe_d    = ~bus.rd_data[7];
          bit_cnt_d   = 4'd0;
          state_d     = S_RDATA;
        end else if (scl_rise_s) begin
          shift_d[0] = sda_f_q;
          bit_cnt_d  = 4'd1;
        end else if (scl_fall_s && (bit_cnt_q == 4'd1)) begin
          bit_cnt_d = 4'd0;
          if (shift_q[0]) begin
            state_d = S_IDLE;
          end else begin
            reg_addr_d = reg_addr_q + 8'd1;
            rd_pend_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: begin
        state_d  = S_IDLE;
        sda_oe_d = 1'b0;
      end
    endcase

    if (stop_s) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_s) begin
      state_d   = S_ADDR;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      bit_cnt_d = 4'd0;
    end else begin
      busy_d = busy_d;
    end
  end

  // FSM and output registers; reset releases SDA without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      wr_data_q   <= 8'h00;
      wr_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
      inc_q       <= 1'b0;
`ifdef I2C_REG_TARGET_READ_EN
      rnw_q       <= 1'b0;
      rd_strobe_q <= 1'b0;
      rd_pend_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
      busy_q      <= busy_d;
      inc_q       <= inc_d;
`ifdef I2C_REG_TARGET_READ_EN
      rnw_q       <= rnw_d;
      rd_strobe_q <= rd_strobe_d;
      rd_pend_q   <= rd_pend_d;
`endif
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.busy      = busy_q;
`ifdef I2C_REG_TARGET_READ_EN
  assign bus.rd_strobe = rd_strobe_q;
`else
  assign bus.rd_strobe = 1'b0;
`endif

endmodule
